// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: holds PCF, selects redirect / stall / BTB target / PC+4,
// and predicts with a direct-mapped BTB of 2-bit saturating counters.
module btb_entry #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  upd_sel,
    input  logic [TAG_W-1:0]      upd_tag,
    input  logic [DATA_WIDTH-1:0] upd_tgt,
    input  logic                  upd_taken,
    output logic                  vld,
    output logic [TAG_W-1:0]      tag,
    output logic [DATA_WIDTH-1:0] tgt,
    output logic [1:0]            ctr
);
    logic upd_hit;
    assign upd_hit = vld && (tag == upd_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            tag <= '0;
            tgt <= '0;
            ctr <= 2'b01;
        end else if (upd_sel) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr <= (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
                    tgt <= upd_tgt;
                end else begin
                    ctr <= (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch replaces whatever aliased into this slot.
                vld <= 1'b1;
                tag <= upd_tag;
                tgt <= upd_tgt;
                ctr <= 2'b10;
            end
        end
    end
endmodule

module fetch_pc_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    BTB_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF_i,
    input  logic                  RedirectE_i,
    input  logic [DATA_WIDTH-1:0] RedirectPCE_i,
    input  logic                  UpdEn_i,
    input  logic [DATA_WIDTH-1:0] UpdPC_i,
    input  logic [DATA_WIDTH-1:0] UpdTarget_i,
    input  logic                  UpdTaken_i,
    output logic [DATA_WIDTH-1:0] PCF_o,
    output logic [DATA_WIDTH-1:0] PCPlus4F_o,
    output logic                  PredTakenF_o,
    output logic [DATA_WIDTH-1:0] PredTargetF_o,
    output logic                  ValidF_o
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
    localparam logic [DATA_WIDTH-1:0] RESET_PC_A = {RESET_PC[DATA_WIDTH-1:2], 2'b00};

    typedef enum logic {BOOT, RUN} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] pcf, pc_nxt, pc_plus4;
    logic [BTB_ENTRIES-1:0]                 btb_vld;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0]      btb_tag;
    logic [BTB_ENTRIES-1:0][DATA_WIDTH-1:0] btb_tgt;
    logic [BTB_ENTRIES-1:0][1:0]            btb_ctr;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit;
    logic [DATA_WIDTH-1:0] up_tgt_a;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        ValidF_o = (state == RUN);
    end

    // Lookup sees the array before any same-cycle update lands.
    assign lk_idx = pcf[IDX_W+1:2];
    assign lk_tag = pcf[DATA_WIDTH-1:IDX_W+2];
    assign lk_hit = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);

    assign pc_plus4      = pcf + DATA_WIDTH'(4);
    assign PCF_o         = pcf;
    assign PCPlus4F_o    = pc_plus4;
    assign PredTakenF_o  = lk_hit && btb_ctr[lk_idx][1];
    assign PredTargetF_o = lk_hit ? btb_tgt[lk_idx] : '0;

    always_comb begin
        pc_nxt = pcf;
        if (state == RUN) begin
            if (RedirectE_i)       pc_nxt = {RedirectPCE_i[DATA_WIDTH-1:2], 2'b00};
            else if (StallF_i)     pc_nxt = pcf;
            else if (PredTakenF_o) pc_nxt = PredTargetF_o;
            else                   pc_nxt = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcf <= RESET_PC_A;
        else        pcf <= pc_nxt;
    end

    assign up_idx   = UpdPC_i[IDX_W+1:2];
    assign up_tag   = UpdPC_i[DATA_WIDTH-1:IDX_W+2];
    assign up_tgt_a = {UpdTarget_i[DATA_WIDTH-1:2], 2'b00};

    for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_btb
        btb_entry #(.DATA_WIDTH(DATA_WIDTH), .TAG_W(TAG_W)) u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .upd_sel   (UpdEn_i && (up_idx == IDX_W'(i))),
            .upd_tag   (up_tag),
            .upd_tgt   (up_tgt_a),
            .upd_taken (UpdTaken_i),
            .vld       (btb_vld[i]),
            .tag       (btb_tag[i]),
            .tgt       (btb_tgt[i]),
            .ctr       (btb_ctr[i])
        );
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Table-driven bench for fetch_pc_unit; expected outputs queued per cycle and
// compared on the falling edge.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF_i, RedirectE_i, UpdEn_i, UpdTaken_i;
    logic [31:0] RedirectPCE_i, UpdPC_i, UpdTarget_i;
    logic [31:0] PCF_o, PCPlus4F_o, PredTargetF_o;
    logic        PredTakenF_o, ValidF_o;

    fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .BTB_ENTRIES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .StallF_i      (StallF_i),
        .RedirectE_i   (RedirectE_i),
        .RedirectPCE_i (RedirectPCE_i),
        .UpdEn_i       (UpdEn_i),
        .UpdPC_i       (UpdPC_i),
        .UpdTarget_i   (UpdTarget_i),
        .UpdTaken_i    (UpdTaken_i),
        .PCF_o         (PCF_o),
        .PCPlus4F_o    (PCPlus4F_o),
        .PredTakenF_o  (PredTakenF_o),
        .PredTargetF_o (PredTargetF_o),
        .ValidF_o      (ValidF_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, redir;
        logic [31:0] rpc;
        logic        upd;
        logic [31:0] upc, utgt;
        logic        utk;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_v;
    } vec_t;

    typedef struct {
        logic [31:0] pc, tgt;
        logic        pt, v;
        int          row;
    } exp_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(inout vec_t t[$], input logic s, input logic r, input logic [31:0] rpc,
                       input logic u, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic utk, input logic [31:0] epc, input logic ept,
                       input logic [31:0] etgt, input logic ev);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.upd = u; v.upc = upc; v.utgt = utgt;
        v.utk = utk; v.e_pc = epc; v.e_pt = ept; v.e_tgt = etgt; v.e_v = ev;
        t.push_back(v);
    endtask

    // One cycle: drive inputs, queue expectation, compare at negedge, advance past posedge.
    task automatic step(input vec_t v, input int row);
        exp_t e, g;
        StallF_i = v.stall; RedirectE_i = v.redir; RedirectPCE_i = v.rpc;
        UpdEn_i = v.upd; UpdPC_i = v.upc; UpdTarget_i = v.utgt; UpdTaken_i = v.utk;
        e.pc = v.e_pc; e.pt = v.e_pt; e.tgt = v.e_tgt; e.v = v.e_v; e.row = row;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty row %0d", row);
        end else begin
            g = exp_q.pop_front();
            chk($sformatf("pcf[%0d]", g.row), PCF_o, g.pc);
            chk($sformatf("pcplus4[%0d]", g.row), PCPlus4F_o, g.pc + 32'd4);
            chk($sformatf("pred_taken[%0d]", g.row), {31'd0, PredTakenF_o}, {31'd0, g.pt});
            chk($sformatf("pred_target[%0d]", g.row), PredTargetF_o, g.tgt);
            chk($sformatf("validf[%0d]", g.row), {31'd0, ValidF_o}, {31'd0, g.v});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           s r rpc            u upc    utgt    tk  e_pc          pt e_tgt   v
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h0,        0, 32'h0,  0);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h0,        0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h4,        0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h8,        0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'hC,        0, 32'h0,  1);
        add(tbl_a, 1,0,32'h0,         0,32'h0, 32'h0,  0, 32'h10,       0, 32'h0,  1);
        add(tbl_a, 1,0,32'h0,         0,32'h0, 32'h0,  0, 32'h10,       0, 32'h0,  1);
        add(tbl_a, 1,0,32'h0,         0,32'h0, 32'h0,  0, 32'h10,       0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h10,       0, 32'h0,  1);
        add(tbl_a, 1,1,32'h102,       0,32'h0, 32'h0,  0, 32'h14,       0, 32'h0,  1);
        add(tbl_a, 0,1,32'h20,        1,32'h20,32'h80, 1, 32'h100,      0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h20,       1, 32'h80, 1);
        add(tbl_a, 0,0,32'h0,         1,32'h20,32'h0,  0, 32'h80,       0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         1,32'h20,32'h0,  0, 32'h84,       0, 32'h0,  1);
        add(tbl_a, 0,1,32'h20,        1,32'h20,32'h0,  0, 32'h88,       0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h20,       0, 32'h80, 1);
        add(tbl_a, 0,1,32'h20,        1,32'h60,32'h203,1, 32'h24,       0, 32'h0,  1);
        add(tbl_a, 0,1,32'h60,        0,32'h0, 32'h0,  0, 32'h20,       0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h60,       1, 32'h200,1);
        add(tbl_a, 0,1,32'h60,        0,32'h0, 32'h0,  0, 32'h200,      0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         1,32'h60,32'h300,1, 32'h60,       1, 32'h200,1);
        add(tbl_a, 0,1,32'h60,        0,32'h0, 32'h0,  0, 32'h200,      0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         1,32'h60,32'h300,1, 32'h60,       1, 32'h300,1);
        add(tbl_a, 0,1,32'h60,        1,32'h60,32'h0,  0, 32'h300,      0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h60,       1, 32'h300,1);
        add(tbl_a, 0,1,32'hFFFF_FFFF, 0,32'h0, 32'h0,  0, 32'h300,      0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'hFFFF_FFFC,0, 32'h0,  1);
        add(tbl_a, 0,1,32'h40,        1,32'h40,32'h500,0, 32'h0,        0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h40,       0, 32'h0,  1);
        add(tbl_a, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h44,       0, 32'h0,  1);
        // After mid-run reset: redirect ignored in BOOT, update still honoured.
        add(tbl_b, 0,1,32'h60,        1,32'h80,32'h400,1, 32'h0,        0, 32'h0,  0);
        add(tbl_b, 0,1,32'h60,        0,32'h0, 32'h0,  0, 32'h0,        0, 32'h0,  1);
        add(tbl_b, 0,1,32'h20,        0,32'h0, 32'h0,  0, 32'h60,       0, 32'h0,  1);
        add(tbl_b, 0,1,32'h80,        0,32'h0, 32'h0,  0, 32'h20,       0, 32'h0,  1);
        add(tbl_b, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h80,       1, 32'h400,1);
        add(tbl_b, 0,0,32'h0,         0,32'h0, 32'h0,  0, 32'h400,      0, 32'h0,  1);

        rst_n = 1'b0;
        StallF_i = 0; RedirectE_i = 0; RedirectPCE_i = 0;
        UpdEn_i = 0; UpdPC_i = 0; UpdTarget_i = 0; UpdTaken_i = 0;
        #2;
        chk("reset_pcf", PCF_o, 32'h0);
        chk("reset_pcplus4", PCPlus4F_o, 32'h4);
        chk("reset_pred_taken", {31'd0, PredTakenF_o}, 32'd0);
        chk("reset_pred_target", PredTargetF_o, 32'h0);
        chk("reset_validf", {31'd0, ValidF_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl_a.size(); i++) step(tbl_a[i], i);

        // Asynchronous reset mid-run with a populated BTB.
        rst_n = 1'b0;
        #1;
        chk("midrst_pcf", PCF_o, 32'h0);
        chk("midrst_validf", {31'd0, ValidF_o}, 32'd0);
        chk("midrst_pred_taken", {31'd0, PredTakenF_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl_b.size(); i++) step(tbl_b[i], 100 + i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
